fir_seq_mac: RTL and testbench
==============================

FIR_SEQ_MAC -- requirements
Module: fir_seq_mac

Interface
REQ-001 Parameter NB_IN, default 32, signed input sample width.
REQ-002 Parameter NB_COEF, default 16, signed coefficient width.
REQ-003 Parameter NTAPS, default 4, tap count (>=2).
REQ-004 Parameter NB_OUT, default 64, signed output width.
REQ-005 Parameter SAT, default 0, overflow mode: 0 = wrap (two's-complement truncation), 1 = saturate.
REQ-006 clk  input  1  single clock; all logic on rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 x  input  NB_IN  signed sample.
REQ-009 in_valid  input  1  x is valid.
REQ-010 in_ready  output  1  block can accept a sample.
REQ-011 y  output  NB_OUT  signed filter result.
REQ-012 out_valid  output  1  y is valid.
REQ-013 out_ready  input  1  consumer accepts y.
REQ-014 coef_we  input  1  coefficient write strobe.
REQ-015 coef_addr  input  clog2(NTAPS)  tap index to write.
REQ-016 coef_data  input  NB_COEF  signed coefficient value.
REQ-017 clr_hist  input  1  clear sample delay line.
REQ-018 ovf  output  1  sticky flag: an output overflowed NB_OUT since reset.

Function
REQ-019 The block SHALL compute y[n] = sum over k=0..NTAPS-1 of h[k]*x[n-k] using a single shared multiplier, one product per cycle.
REQ-020 The accumulator SHALL be NB_IN+NB_COEF+clog2(NTAPS) bits wide and SHALL never overflow internally.
REQ-021 The FSM SHALL have states IDLE, MAC, OUT; IDLE->MAC on in_valid&in_ready, MAC->OUT after the NTAPS-th product is accumulated, OUT->IDLE on out_ready.
REQ-022 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in OUT.
REQ-023 On accept, the delay line SHALL shift (d[0]=x, d[k]=d[k-1]) and the accumulator SHALL clear.
REQ-024 Latency SHALL be exactly NTAPS+1 cycles from the accept edge to out_valid rising, with out_ready held high.
REQ-025 With out_ready low, y and out_valid SHALL hold unchanged and no new sample SHALL be accepted.
REQ-026 When the accumulator exceeds the NB_OUT signed range: SAT=1 clamps y to max/min NB_OUT value; SAT=0 keeps the low NB_OUT bits; in both modes ovf SHALL set.
REQ-027 When the accumulator fits NB_OUT, y SHALL be its sign-extended value.
REQ-028 A coefficient write SHALL take effect only in IDLE; coef_we in MAC or OUT SHALL be ignored.
REQ-029 coef_addr >= NTAPS SHALL be ignored.
REQ-030 coef_we together with an accepted sample in the same IDLE cycle SHALL apply the write first; that sample SHALL use the new coefficient.
REQ-031 clr_hist SHALL zero the delay line only in IDLE; clr_hist together with an accepted sample SHALL leave d[0]=x and all other taps 0.

Reset
REQ-032 rst SHALL force state IDLE, y=0, out_valid=0, in_ready=1 (on the cycle after rst deasserts), ovf=0, accumulator 0, delay line 0.
REQ-033 rst SHALL set h[0]=1 and h[1..NTAPS-1]=0 (pass-through).
REQ-034 rst asserted in MAC or OUT SHALL abort the computation and discard the result, with no out_valid pulse.

Verification
REQ-035 Pass-through: after reset, samples 5,-3,7 -> y = 5,-3,7, each NTAPS+1 cycles after accept.
REQ-036 Impulse: h = 1,-1,1,1, samples 1,0,0,0,0 -> y = 1,-1,1,1,0.
REQ-037 Back-pressure: out_ready low for 5 cycles in OUT -> y and out_valid stable, in_ready=0, in_valid ignored; then out_ready=1 -> IDLE on the next cycle.
REQ-038 Overflow: NB_IN=8, NB_OUT=8, h[0]=2, x=100 -> SAT=1: y=127, ovf=1; SAT=0: y=-56, ovf=1.
REQ-039 Illegal writes: coef_we asserted in MAC and coef_addr=NTAPS asserted in IDLE -> coefficients unchanged, result matches the prior h.
REQ-040 Reset mid-MAC: rst two cycles after accept -> no out_valid, h back to pass-through, next sample 9 -> y=9.

Source files
------------

// File: rtl/fir_seq_mac.sv
// Sequential FIR filter: one shared multiplier walks the taps, one product per cycle.
// Results leave through a valid/ready handshake, with optional output saturation and a sticky overflow flag.
module fir_seq_mac #(
    parameter int NB_IN   = 32,
    parameter int NB_COEF = 16,
    parameter int NTAPS   = 4,
    parameter int NB_OUT  = 64,
    parameter int SAT     = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic signed [NB_IN-1:0]     x,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic signed [NB_OUT-1:0]    y,
    output logic                        out_valid,
    input  logic                        out_ready,
    input  logic                        coef_we,
    input  logic [$clog2(NTAPS)-1:0]    coef_addr,
    input  logic signed [NB_COEF-1:0]   coef_data,
    input  logic                        clr_hist,
    output logic                        ovf
);

    localparam int AW    = $clog2(NTAPS);
    localparam int CW    = $clog2(NTAPS + 1);
    localparam int PW    = NB_IN + NB_COEF;
    localparam int ACC_W = PW + $clog2(NTAPS);
    localparam int XW    = (ACC_W > NB_OUT) ? ACC_W : NB_OUT;

    localparam logic signed [NB_OUT-1:0] Y_MAX = {1'b0, {(NB_OUT-1){1'b1}}};
    localparam logic signed [NB_OUT-1:0] Y_MIN = {1'b1, {(NB_OUT-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                     state;
    state_t                     state_nxt;
    logic signed [NB_COEF-1:0]  h [NTAPS];
    logic signed [NB_IN-1:0]    d [NTAPS];
    logic [CW-1:0]              cnt;
    logic [AW-1:0]              tap;
    logic signed [PW-1:0]       prod_p0;
    logic signed [ACC_W-1:0]    acc_p1;
    logic                       accept;
    logic                       mac_done;
    logic                       coef_ok;

    // True when the accumulator does not survive the round trip through NB_OUT bits.
    function automatic logic out_ovf(input logic signed [ACC_W-1:0] a);
        logic signed [XW-1:0]     wide;
        logic signed [NB_OUT-1:0] low;
        wide = XW'(a);
        low  = NB_OUT'(wide);
        return XW'(low) != wide;
    endfunction

    function automatic logic signed [NB_OUT-1:0] out_fit(input logic signed [ACC_W-1:0] a);
        logic signed [XW-1:0] wide;
        wide = XW'(a);
        if (SAT != 0 && out_ovf(a))
            return wide[XW-1] ? Y_MIN : Y_MAX;
        return NB_OUT'(wide);
    endfunction

    assign accept   = in_valid && (state == IDLE);
    assign mac_done = (cnt == CW'(NTAPS));
    assign coef_ok  = int'(coef_addr) < NTAPS;
    assign tap      = cnt[AW-1:0];
    assign prod_p0  = PW'(h[tap]) * PW'(d[tap]);

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_nxt = MAC;
            end
            MAC: begin
                if (mac_done)
                    state_nxt = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NTAPS; k++) begin
                d[k] <= '0;
                h[k] <= '0;
            end
            h[0]   <= NB_COEF'(1);
            acc_p1 <= '0;
            cnt    <= '0;
            y      <= '0;
            ovf    <= 1'b0;
        end else begin
            // Coefficient write lands on the accept edge, so the new sample already sees it.
            if (state == IDLE) begin
                if (coef_we && coef_ok)
                    h[coef_addr] <= coef_data;
                if (accept) begin
                    d[0] <= x;
                    for (int k = 1; k < NTAPS; k++)
                        d[k] <= clr_hist ? '0 : d[k-1];
                    acc_p1 <= '0;
                    cnt    <= '0;
                end else if (clr_hist) begin
                    for (int k = 0; k < NTAPS; k++)
                        d[k] <= '0;
                end
            end
            // MAC stage: one tap per cycle, then one extra cycle to format the result.
            if (state == MAC) begin
                if (!mac_done) begin
                    acc_p1 <= acc_p1 + ACC_W'(prod_p0);
                    cnt    <= cnt + CW'(1);
                end else begin
                    y   <= out_fit(acc_p1);
                    ovf <= ovf | out_ovf(acc_p1);
                end
            end
        end
    end

endmodule

// File: tb/tb_fir_seq_mac.sv
// Directed bench for fir_seq_mac: a default-width instance for filtering/handshake
// and two narrow 8-bit instances for saturate and wrap behaviour.
module tb_fir_seq_mac;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // main instance (defaults)
    logic signed [31:0] x;
    logic               in_valid, in_ready, out_valid, out_ready;
    logic signed [63:0] y;
    logic               coef_we, clr_hist, ovf;
    logic [1:0]         coef_addr;
    logic signed [15:0] coef_data;

    // narrow instances share their inputs
    logic signed [7:0]  sx;
    logic               s_in_valid, s_out_ready, s_coef_we, s_clr;
    logic [1:0]         s_coef_addr;
    logic signed [15:0] s_coef_data;
    logic               sat_in_ready, sat_out_valid, sat_ovf;
    logic signed [7:0]  sat_y;
    logic               wrp_in_ready, wrp_out_valid, wrp_ovf;
    logic signed [7:0]  wrp_y;

    int total = 0;
    int bad   = 0;

    fir_seq_mac dut (
        .clk(clk), .rst(rst), .x(x), .in_valid(in_valid), .in_ready(in_ready),
        .y(y), .out_valid(out_valid), .out_ready(out_ready), .coef_we(coef_we),
        .coef_addr(coef_addr), .coef_data(coef_data), .clr_hist(clr_hist), .ovf(ovf)
    );

    fir_seq_mac #(.NB_IN(8), .NB_OUT(8), .NTAPS(4), .SAT(1)) dut_sat (
        .clk(clk), .rst(rst), .x(sx), .in_valid(s_in_valid), .in_ready(sat_in_ready),
        .y(sat_y), .out_valid(sat_out_valid), .out_ready(s_out_ready), .coef_we(s_coef_we),
        .coef_addr(s_coef_addr), .coef_data(s_coef_data), .clr_hist(s_clr), .ovf(sat_ovf)
    );

    fir_seq_mac #(.NB_IN(8), .NB_OUT(8), .NTAPS(3), .SAT(0)) dut_wrp (
        .clk(clk), .rst(rst), .x(sx), .in_valid(s_in_valid), .in_ready(wrp_in_ready),
        .y(wrp_y), .out_valid(wrp_out_valid), .out_ready(s_out_ready), .coef_we(s_coef_we),
        .coef_addr(s_coef_addr), .coef_data(s_coef_data), .clr_hist(s_clr), .ovf(wrp_ovf)
    );

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wr_coef(input logic [1:0] a, input logic signed [15:0] v);
        coef_we = 1'b1; coef_addr = a; coef_data = v;
        @(negedge clk);
        coef_we = 1'b0;
    endtask

    // Called at a negedge with the DUT idle; any clr_hist/coef_we set by the caller rides the accept.
    task automatic sample(input logic signed [31:0] xv, input logic signed [63:0] yexp, input string tag);
        int n;
        chk({tag, "_rdy"}, in_ready, 1);
        x = xv; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; clr_hist = 1'b0; coef_we = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat"}, 64'(n), 5);
        chk(tag, y, yexp);
        @(negedge clk);
    endtask

    initial begin
        int n;
        int seen;
        rst = 1'b1; x = '0; in_valid = 1'b0; out_ready = 1'b1;
        coef_we = 1'b0; coef_addr = '0; coef_data = '0; clr_hist = 1'b0;
        sx = '0; s_in_valid = 1'b0; s_out_ready = 1'b1; s_coef_we = 1'b0;
        s_coef_addr = '0; s_coef_data = '0; s_clr = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_y", y, 0);
        chk("rst_ovf", ovf, 0);

        // pass-through coefficients after reset
        sample(5, 5, "pass0");
        sample(-3, -3, "pass1");
        sample(7, 7, "pass2");

        // impulse response with h = 1,-1,1,1
        wr_coef(2'd1, -16'sd1);
        wr_coef(2'd2, 16'sd1);
        wr_coef(2'd3, 16'sd1);
        clr_hist = 1'b1;
        @(negedge clk);
        clr_hist = 1'b0;
        sample(1, 1, "imp0");
        sample(0, -1, "imp1");
        sample(0, 1, "imp2");
        sample(0, 1, "imp3");
        sample(0, 0, "imp4");

        // write-first and history clear on the accept cycle: h0 -> 5, d = [2,0,0,0]
        sample(3, 3, "pre_wf");
        clr_hist = 1'b1; coef_we = 1'b1; coef_addr = 2'd0; coef_data = 16'sd5;
        sample(2, 10, "wr_first");

        // back-pressure: d = [4,2,0,0] -> 5*4 - 2 = 18
        out_ready = 1'b0;
        x = 4; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bp_lat", 64'(n), 5);
        chk("bp_y", y, 18);
        x = 99; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_vld", out_valid, 1);
            chk("bp_hold_y", y, 18);
            chk("bp_in_ready", in_ready, 0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_vld", out_valid, 0);
        chk("bp_release_rdy", in_ready, 1);
        // the held-off 99 must not be in history: d = [0,4,2,0] -> -4 + 2
        sample(0, -2, "bp_after");

        // write during MAC ignored: d = [1,0,4,2] -> 5+0+4+2
        x = 1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        coef_we = 1'b1; coef_addr = 2'd0; coef_data = 16'sd100;
        @(negedge clk);
        @(negedge clk);
        coef_we = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("macwe_y", y, 11);
        @(negedge clk);
        // d = [1,1,0,4] -> 5 - 1 + 0 + 4 with the original h0
        sample(1, 8, "macwe_after");

        // reset two cycles after accept
        x = 6; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) seen++;
            @(negedge clk);
        end
        chk("rstmac_no_vld", 64'(seen), 0);
        sample(9, 9, "rstmac_pass");

        // narrow instances: h0 = 2, x = 100 -> accumulator 200
        chk("sat_ovf_init", sat_ovf, 0);
        chk("wrp_ovf_init", wrp_ovf, 0);
        s_coef_we = 1'b1; s_coef_addr = 2'd0; s_coef_data = 16'sd2;
        @(negedge clk);
        s_coef_we = 1'b0;
        s_out_ready = 1'b0;
        sx = 8'sd100; s_in_valid = 1'b1;
        @(negedge clk);
        s_in_valid = 1'b0;
        n = 0;
        while (!(sat_out_valid && wrp_out_valid) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("narrow_timeout", 64'(n < 20), 1);
        chk("sat_y", sat_y, 127);
        chk("sat_ovf", sat_ovf, 1);
        chk("wrp_y", wrp_y, -56);
        chk("wrp_ovf", wrp_ovf, 1);
        s_out_ready = 1'b1;
        @(negedge clk);

        // out-of-range address on the 3-tap instance, then x = 3 -> 2*3 + 0*100
        s_coef_we = 1'b1; s_coef_addr = 2'd3; s_coef_data = 16'sd7;
        @(negedge clk);
        s_coef_we = 1'b0;
        sx = 8'sd3; s_in_valid = 1'b1;
        @(negedge clk);
        s_in_valid = 1'b0;
        n = 0;
        while (!wrp_out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("wrp_lat", 64'(n), 4);
        chk("wrp_badaddr_y", wrp_y, 6);
        chk("wrp_ovf_sticky", wrp_ovf, 1);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
